// File: rtl/cpu_memory_pkg.sv
// Shared definitions for the cpu_memory slice.
//   DATA_W_DEF / ADDR_W_DEF : default word and address widths
//   bus_word_t              : one word as carried on d_bus
//   drive_sel_t             : which output register (if any) owns d_bus
//   pick_driver()           : bus ownership decision from the control inputs
package cpu_memory_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;

  typedef logic [DATA_W_DEF-1:0] bus_word_t;

  typedef enum logic [1:0] {
    DRV_NONE  = 2'd0,
    DRV_DATA  = 2'd1,
    DRV_INSTR = 2'd2
  } drive_sel_t;

  // An external write always wins so this block never fights the bus master;
  // otherwise the data register has priority over the instruction register.
  function automatic drive_sel_t pick_driver(input logic d_write,
                                             input logic d_push,
                                             input logic i_push);
    if (d_write)     return DRV_NONE;
    else if (d_push) return DRV_DATA;
    else if (i_push) return DRV_INSTR;
    else             return DRV_NONE;
  endfunction

endpackage

// File: rtl/cpu_mem_array.sv
// Dual-port word RAM: one read/write port (data) and one read-only port
// (instruction), both with registered read-first outputs.
//   clk      : clock
//   clr      : synchronous clear of both read registers (contents untouched)
//   d_we     : write d_wdata to mem[d_addr]
//   d_re     : load d_rdata from mem[d_addr]
//   d_addr   : data port address
//   d_wdata  : write data
//   d_rdata  : registered data-port read word
//   i_re     : load i_rdata from mem[i_addr]
//   i_addr   : instruction port address
//   i_rdata  : registered instruction-port read word
module cpu_mem_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              d_we,
  input  logic              d_re,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage has no reset so it can map onto a RAM macro.
  always_ff @(posedge clk) begin
    if (d_we) mem[d_addr] <= d_wdata;
  end

  // Non-blocking reads sample the pre-write word, giving read-first
  // behaviour when a read and a write hit the same address.
  always_ff @(posedge clk) begin
    if (clr) begin
      d_rdata <= '0;
    end else if (d_re) begin
      d_rdata <= mem[d_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      i_rdata <= '0;
    end else if (i_re) begin
      i_rdata <= mem[i_addr];
    end
  end

endmodule

// File: rtl/cpu_memory.sv
// Unified CPU RAM with a data port and an instruction port sharing d_bus.
//   clk     : clock, rising edge
//   rst     : synchronous active-high; clears d_reg/i_reg, ignores reads/writes
//   d_read  : latch mem[d_addr] into d_reg
//   d_write : write d_bus into mem[d_addr] (bus driven externally)
//   d_push  : drive d_reg onto d_bus
//   i_read  : latch mem[i_addr] into i_reg
//   i_push  : drive i_reg onto d_bus (lower priority than d_push)
//   d_addr  : data address
//   i_addr  : instruction address
//   d_bus   : shared bidirectional bus, high-Z unless pushed
module cpu_memory
  import cpu_memory_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_read,
  input  logic              d_write,
  input  logic              d_push,
  input  logic              i_read,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [ADDR_W-1:0] i_addr,
  inout  wire  [DATA_W-1:0] d_bus
);

  logic [DATA_W-1:0] d_reg;
  logic [DATA_W-1:0] i_reg;
  logic [DATA_W-1:0] bus_out;
  logic              drive_en;

  // Writes are gated by reset so memory is untouched during a reset edge;
  // read enables are overridden by clr inside the array.
  cpu_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .clr     (rst),
    .d_we    (d_write & ~rst),
    .d_re    (d_read),
    .d_addr  (d_addr),
    .d_wdata (d_bus),
    .d_rdata (d_reg),
    .i_re    (i_read),
    .i_addr  (i_addr),
    .i_rdata (i_reg)
  );

  always_comb begin
    bus_out  = '0;
    drive_en = 1'b0;
    case (pick_driver(d_write, d_push, i_push))
      DRV_DATA: begin
        bus_out  = d_reg;
        drive_en = 1'b1;
      end
      DRV_INSTR: begin
        bus_out  = i_reg;
        drive_en = 1'b1;
      end
      default: begin
        bus_out  = '0;
        drive_en = 1'b0;
      end
    endcase
  end

  assign d_bus = drive_en ? bus_out : 'z;

endmodule

// File: tb/tb_cpu_memory.sv
module tb_cpu_memory;
  import cpu_memory_pkg::*;

  logic        clk = 1'b0;
  logic        rst, d_read, d_write, d_push, i_read, i_push;
  logic [15:0] d_addr, i_addr;
  bus_word_t   ext_val;
  logic        tb_en;
  wire  [15:0] d_bus;

  always #5 clk = ~clk;

  // External master: drives the write word on writes, otherwise a random
  // probe whenever the block is expected to have released the bus.
  assign d_bus = tb_en ? ext_val : 'z;

  cpu_memory #(.DATA_W(16), .ADDR_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .d_read  (d_read),
    .d_write (d_write),
    .d_push  (d_push),
    .i_read  (i_read),
    .i_push  (i_push),
    .d_addr  (d_addr),
    .i_addr  (i_addr),
    .d_bus   (d_bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: sparse memory plus the two latched words.
  bus_word_t m_mem [int];
  bus_word_t m_dreg, m_ireg;

  function automatic bus_word_t m_rd(input logic [15:0] a);
    if (m_mem.exists(int'(a))) return m_mem[int'(a)];
    return 'x;
  endfunction

  function automatic bus_word_t expected_bus();
    if (d_write)     return ext_val;
    else if (d_push) return m_dreg;
    else if (i_push) return m_ireg;
    else             return ext_val;
  endfunction

  task automatic check(input string tag, input bus_word_t obs, input bus_word_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bus(input string tag);
    tb_en = d_write | ~(d_push | i_push);
    if (!d_write) ext_val = bus_word_t'($urandom);
    #1;
    check(tag, d_bus, expected_bus());
  endtask

  task automatic tick();
    bus_word_t old_d, old_i;
    @(posedge clk);
    if (rst) begin
      m_dreg = '0;
      m_ireg = '0;
    end else begin
      old_d = m_rd(d_addr);
      old_i = m_rd(i_addr);
      if (d_read)  m_dreg = old_d;
      if (i_read)  m_ireg = old_i;
      if (d_write) m_mem[int'(d_addr)] = ext_val;
    end
    #1;
  endtask

  task automatic cycle(input string tag);
    check_bus(tag);
    tick();
  endtask

  int pool [8] = '{289, 5, 10, 300, 999, 0, 65535, 1234};

  initial begin
    rst = 1'b1; d_read = 0; d_write = 0; d_push = 0; i_read = 0; i_push = 0;
    d_addr = '0; i_addr = '0; ext_val = '0; tb_en = 1'b1;
    tick();
    rst = 1'b0;

    d_push = 1; check_bus("rst_dpush"); check("rst_dpush_zero", d_bus, 16'd0);
    d_push = 0; i_push = 1; check_bus("rst_ipush"); check("rst_ipush_zero", d_bus, 16'd0);
    i_push = 0;

    // write / read / push
    d_addr = 16'd289; ext_val = 16'd47; d_write = 1; cycle("wr289"); d_write = 0;
    d_read = 1; cycle("rd289"); d_read = 0;
    d_push = 1; check_bus("push289"); check("push289_const", d_bus, 16'd47);

    // bus release
    d_addr = 16'd999; ext_val = bus_word_t'($urandom); d_write = 1;
    check_bus("release_wr"); tick();
    d_write = 0; d_push = 0; check_bus("release_idle");

    // instruction path and priority
    d_addr = 16'd5; ext_val = 16'h1234; d_write = 1; cycle("wr5"); d_write = 0;
    i_addr = 16'd5; i_read = 1; cycle("ird5"); i_read = 0;
    i_push = 1; check_bus("ipush5"); check("ipush5_const", d_bus, 16'h1234);
    d_push = 1; check_bus("prio"); check("prio_const", d_bus, 16'd47);
    d_push = 0; i_push = 0;

    // read-first on both ports
    d_addr = 16'd10; ext_val = 16'd7; d_write = 1; cycle("wr10");
    ext_val = 16'd9; d_read = 1; i_addr = 16'd10; i_read = 1; cycle("rf_wr10");
    d_write = 0; i_read = 0; d_push = 1;
    check_bus("rf_old"); check("rf_old_const", d_bus, 16'd7);
    tick(); d_read = 0;
    check_bus("rf_new"); check("rf_new_const", d_bus, 16'd9);
    d_push = 0; i_push = 1; check_bus("rf_ireg"); check("rf_ireg_const", d_bus, 16'd7);
    i_push = 0;

    // reset clears registers, ignores write, keeps memory
    d_addr = 16'd289; i_addr = 16'd5; d_read = 1; i_read = 1; cycle("load_regs");
    rst = 1; d_write = 1; ext_val = 16'hdead; cycle("rst_cycle");
    rst = 0; d_write = 0; d_read = 0; i_read = 0;
    d_push = 1; check_bus("post_rst_d"); check("post_rst_d_zero", d_bus, 16'd0);
    d_push = 0; i_push = 1; check_bus("post_rst_i"); check("post_rst_i_zero", d_bus, 16'd0);
    i_push = 0; d_read = 1; cycle("rd289_again"); d_read = 0;
    d_push = 1; check_bus("mem_kept"); check("mem_kept_const", d_bus, 16'd47);

    // concurrent push + read
    d_push = 0; d_addr = 16'd300; ext_val = 16'd88; d_write = 1; cycle("wr300"); d_write = 0;
    d_read = 1; d_push = 1;
    check_bus("cc_before"); check("cc_before_const", d_bus, 16'd47);
    tick();
    check_bus("cc_after"); check("cc_after_const", d_bus, 16'd88);
    d_read = 0; d_push = 0;

    // preload remaining pool entries
    for (int k = 5; k < 8; k++) begin
      d_addr = 16'(pool[k]); ext_val = bus_word_t'($urandom); d_write = 1; cycle("preload");
    end
    d_write = 0;

    // randomized traffic over the pool
    for (int n = 0; n < 400; n++) begin
      rst     = ($urandom_range(0, 31) == 0);
      d_read  = 1'($urandom);
      d_write = 1'($urandom);
      d_push  = 1'($urandom);
      i_read  = 1'($urandom);
      i_push  = 1'($urandom);
      d_addr  = 16'(pool[$urandom_range(0, 7)]);
      i_addr  = 16'(pool[$urandom_range(0, 7)]);
      if (d_write) ext_val = bus_word_t'($urandom);
      cycle("rand");
    end
    rst = 0; d_read = 0; d_write = 0; d_push = 0; i_read = 0; i_push = 0;
    check_bus("final_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
